// File: rtl/mrd_rdx_mem_wr.sv
`default_nettype none
// ============================================================================
// Module   : mrd_rdx_mem_wr
// Brief    : Mixed-radix DFT write-back stage: 5x5 lane-to-bank crossbar,
//            per-stage vector counting, stage completion and sticky errors.
// Revision : 1.0
// ============================================================================
module mrd_rdx_mem_wr #(
    parameter int WDATA = 18,
    parameter int WADDR = 8,
    parameter int WCNT  = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stage_start,
    input  logic [WCNT-1:0]         stage_len,
    input  logic                    err_clr,
    input  logic                    in_valid,
    input  logic signed [WDATA-1:0] in_real       [0:4],
    input  logic signed [WDATA-1:0] in_imag       [0:4],
    input  logic [2:0]              in_bank_index [0:4],
    input  logic [WADDR-1:0]        in_bank_addr  [0:4],
    input  logic [3:0]              in_exp,
    output logic                    wr_en         [0:4],
    output logic [WADDR-1:0]        wr_addr       [0:4],
    output logic [2*WDATA-1:0]      wr_data       [0:4],
    output logic                    stage_done,
    output logic [3:0]              exp_stage,
    output logic                    busy,
    output logic                    err_conflict,
    output logic                    err_index,
    output logic                    err_unexp
);

    localparam int c_LANES = 5;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WCNT-1:0] r_cnt;
    logic [WCNT-1:0] w_cnt_nxt;
    logic [WCNT-1:0] r_len;
    logic [WCNT-1:0] w_len_nxt;
    logic [WCNT-1:0] w_cnt_inc;
    logic            w_accept;
    logic            w_done_nxt;
    logic            w_exp_ld;
    logic            w_unexp;
    logic            w_conflict;
    logic            w_index;
    logic            w_sel_vld  [0:c_LANES-1];
    logic [2:0]      w_sel_lane [0:c_LANES-1];

    // Lowest lane claiming a bank wins; any further claimant is a conflict.
    always_comb begin
        w_conflict = 1'b0;
        w_index    = 1'b0;
        for (int b = 0; b < c_LANES; b++) begin
            w_sel_vld[b]  = 1'b0;
            w_sel_lane[b] = 3'd0;
            for (int k = 0; k < c_LANES; k++) begin
                if (in_bank_index[k] == 3'(b)) begin
                    if (w_sel_vld[b]) begin
                        w_conflict = 1'b1;
                    end else begin
                        w_sel_vld[b]  = 1'b1;
                        w_sel_lane[b] = 3'(k);
                    end
                end
            end
        end
        for (int k = 0; k < c_LANES; k++) begin
            if (in_bank_index[k] > 3'd4) begin
                w_index = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_done_nxt  = 1'b0;
        w_exp_ld    = 1'b0;
        w_unexp     = 1'b0;
        w_cnt_inc   = r_cnt + WCNT'(1);
        w_accept    = in_valid && (stage_start || (r_state == ST_ACTIVE));
        if (stage_start) begin
            // A vector arriving with stage_start is the first of the new stage.
            w_len_nxt = stage_len;
            w_unexp   = (r_state == ST_ACTIVE);
            w_cnt_nxt = '0;
            if (stage_len == '0) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end else if (in_valid && (stage_len == WCNT'(1))) begin
                w_done_nxt  = 1'b1;
                w_exp_ld    = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_ACTIVE;
                w_cnt_nxt   = in_valid ? WCNT'(1) : '0;
            end
        end else if (r_state == ST_ACTIVE) begin
            if (in_valid) begin
                if (w_cnt_inc == r_len) begin
                    w_done_nxt  = 1'b1;
                    w_exp_ld    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        end else if (in_valid) begin
            w_unexp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            stage_done   <= 1'b0;
            exp_stage    <= 4'd0;
            err_conflict <= 1'b0;
            err_index    <= 1'b0;
            err_unexp    <= 1'b0;
            for (int b = 0; b < c_LANES; b++) begin
                wr_en[b]   <= 1'b0;
                wr_addr[b] <= '0;
                wr_data[b] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            stage_done <= w_done_nxt;
            if (w_exp_ld) begin
                exp_stage <= in_exp;
            end
            // New error events take priority over a simultaneous clear.
            err_conflict <= (err_conflict & ~err_clr) | (w_accept & w_conflict);
            err_index    <= (err_index & ~err_clr) | (w_accept & w_index);
            err_unexp    <= (err_unexp & ~err_clr) | w_unexp;
            for (int b = 0; b < c_LANES; b++) begin
                wr_en[b] <= w_accept & w_sel_vld[b];
                if (w_accept && w_sel_vld[b]) begin
                    wr_addr[b] <= in_bank_addr[w_sel_lane[b]];
                    wr_data[b] <= {in_imag[w_sel_lane[b]], in_real[w_sel_lane[b]]};
                end
            end
        end
    end

    assign busy = (r_state == ST_ACTIVE);

endmodule
`default_nettype wire
